// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and width helper for the synchronous FIFO
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 10;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_AF_THRESH  = 6;
  localparam int DEF_AE_THRESH  = 2;

  // Smallest r with 2**r >= value; used to size pointers from the depth.
  function automatic int fifo_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - dual-port register array with a registered, resettable read port
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Array is never cleared; the FIFO pointers make stale words unreachable.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Non-blocking read of the old word gives read-before-write on a shared address.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - synchronous FIFO pointers, count and flags; FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH  = DEF_AF_THRESH,
  parameter int AE_THRESH  = DEF_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] Fifo_Data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PTR_W = fifo_clog2(DEPTH) + 1;
  localparam int CNT_W = ADDR_WIDTH + 1;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] CNT_AE    = CNT_W'(AE_THRESH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             data_valid_q;
  logic             wr_ok, rd_ok;

  // A push on full is accepted only when a pop frees the slot in the same cycle.
  assign wr_ok = push && (!full || pop);
  assign rd_ok = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CNT_ONE;
    end else if (!wr_ok && rd_ok) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_valid_q <= rd_ok;
    end
  end

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk      (clk),
    .reset    (reset),
    .wr_en_i  (wr_ok),
    .wr_addr_i(wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data_i(Fifo_Data_in),
    .rd_en_i  (rd_ok),
    .rd_addr_i(rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data_o(Fifo_Data_out)
  );

  assign count        = count_q;
  assign data_valid   = data_valid_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_DEPTH);
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push && full && !pop) overflow_q <= 1'b1;
      if (pop && empty)         underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// tb/tb_fifo_sync.sv - directed vector bench for fifo_sync with default parameters
module tb_fifo_sync;

  localparam bit ERR_EN =
`ifdef FIFO_ERR_FLAGS_EN
    1'b1;
`else
    1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       push;
  logic [9:0] Fifo_Data_in;
  logic       pop;
  logic [9:0] Fifo_Data_out;
  logic       data_valid;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  fifo_sync dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .Fifo_Data_in (Fifo_Data_in),
    .pop          (pop),
    .Fifo_Data_out(Fifo_Data_out),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         push;
    bit         pop;
    logic [9:0] din;
    int         cnt;
    bit         dv;
    logic [9:0] dout;
    bit         ovf;
    bit         unf;
  } vec_t;

  vec_t       vecs[$];
  int         n_cmp;
  int         n_bad;
  logic [9:0] held_dout;
  bit         ovf_sticky;
  bit         unf_sticky;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Flag expectations are derived from the expected occupancy with the default thresholds.
  task automatic check_state(input string tag, input int cnt, input bit dv, input logic [9:0] dout,
                             input bit ovf, input bit unf);
    chk({tag, " count"}, int'(count), cnt);
    chk({tag, " full"}, int'(full), int'(cnt == 8));
    chk({tag, " empty"}, int'(empty), int'(cnt == 0));
    chk({tag, " almost_full"}, int'(almost_full), int'(cnt >= 6));
    chk({tag, " almost_empty"}, int'(almost_empty), int'(cnt <= 2));
    chk({tag, " data_valid"}, int'(data_valid), int'(dv));
    chk({tag, " data_out"}, int'(Fifo_Data_out), int'(dout));
    chk({tag, " overflow"}, int'(overflow), int'(ovf & ERR_EN));
    chk({tag, " underflow"}, int'(underflow), int'(unf & ERR_EN));
  endtask

  task automatic step(input bit ps, input bit pp, input logic [9:0] d, input bit rs);
    push         = ps;
    pop          = pp;
    Fifo_Data_in = d;
    reset        = rs;
    @(posedge clk);
    #1;
    push  = 1'b0;
    pop   = 1'b0;
    reset = 1'b0;
  endtask

  task automatic add_vec(input bit ps, input bit pp, input logic [9:0] d, input int cnt,
                         input bit dv, input logic [9:0] dout, input bit ovf_evt, input bit unf_evt);
    vec_t v;
    if (dv) held_dout = dout;
    ovf_sticky = ovf_sticky | ovf_evt;
    unf_sticky = unf_sticky | unf_evt;
    v.push = ps;
    v.pop  = pp;
    v.din  = d;
    v.cnt  = cnt;
    v.dv   = dv;
    v.dout = held_dout;
    v.ovf  = ovf_sticky;
    v.unf  = unf_sticky;
    vecs.push_back(v);
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    held_dout    = '0;
    ovf_sticky   = 1'b0;
    unf_sticky   = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    Fifo_Data_in = '0;
    reset        = 1'b1;

    // Fill to full, one rejected push, drain, one rejected pop.
    for (int i = 1; i <= 8; i++) add_vec(1, 0, 10'(i), i, 0, 0, 0, 0);
    add_vec(1, 0, 10'h009, 8, 0, 0, 1, 0);
    for (int i = 1; i <= 8; i++) add_vec(0, 1, 0, 8 - i, 1, 10'(i), 0, 0);
    add_vec(0, 1, 0, 0, 0, 0, 0, 1);
    // Three push-5/pop-5 passes carry both pointers across the wrap.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 5; i++) add_vec(1, 0, 10'(12'h100 + p * 5 + i), i + 1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) add_vec(0, 1, 0, 4 - i, 1, 10'(12'h100 + p * 5 + i), 0, 0);
    end
    // Push+pop on full: oldest word out, new word queued behind seven others.
    for (int i = 1; i <= 8; i++) add_vec(1, 0, 10'(i), i, 0, 0, 0, 0);
    add_vec(1, 1, 10'h3FF, 8, 1, 10'h001, 0, 0);
    for (int k = 1; k <= 8; k++) add_vec(0, 1, 0, 8 - k, 1, (k < 8) ? 10'(k + 1) : 10'h3FF, 0, 0);

    @(posedge clk);
    @(posedge clk);
    #1;
    check_state("reset", 0, 0, 10'h000, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].din, 1'b0);
      check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dv, vecs[i].dout,
                  vecs[i].ovf, vecs[i].unf);
    end

    // Reset with a push pending at count 4 must win and store nothing.
    for (int i = 0; i < 4; i++) step(1, 0, 10'(12'h0A0 + i), 1'b0);
    chk("pre-reset count", int'(count), 4);
    step(1, 0, 10'h055, 1'b1);
    check_state("reset-push", 0, 0, 10'h000, 0, 0);
    step(0, 1, 0, 1'b0);
    check_state("post-reset pop", 0, 0, 10'h000, 0, 1);

    // Write at edge N, pop at edge N+1.
    step(1, 0, 10'h2AA, 1'b0);
    check_state("w2r push", 1, 0, 10'h000, 0, 1);
    step(0, 1, 0, 1'b0);
    check_state("w2r pop", 0, 1, 10'h2AA, 0, 1);

    // Push and pop together on empty: no bypass, word stays queued.
    step(1, 1, 10'h111, 1'b0);
    check_state("no-bypass", 1, 0, 10'h2AA, 0, 1);
    step(0, 1, 0, 1'b0);
    check_state("no-bypass pop", 0, 1, 10'h111, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
